// File: rtl/cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl
// Captures one camera frame (RGB565, two bytes per pixel, high byte first)
// into a frame buffer as RGB444 words, one write pulse per pixel.
//
// Ports
//   clk_w      in   pixel clock, also clocks the buffer write port
//   reset      in   asynchronous, active-high reset
//   vsync      in   frame sync, high between frames
//   href       in   line valid, high while the bytes of a line are present
//   px_data    in   camera byte, sampled on every clk_w rise while href=1
//   arm        in   one-cycle capture request (accepted only when idle)
//   cont       in   1 = re-arm automatically after every frame
//   addr_in    out  buffer write address
//   data_in    out  buffer write data (RGB444)
//   regwrite   out  buffer write enable, one pulse per pixel
//   busy       out  capture in progress (also through DONE when re-arming)
//   done       out  one-cycle pulse at frame completion
//   frame_err  out  sticky frame error, cleared by arm or reset
// -----------------------------------------------------------------------------
module cam_capture_ctrl #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          clk_w,
    input  logic          reset,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    input  logic          arm,
    input  logic          cont,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          busy,
    output logic          done,
    output logic          frame_err
);

    // state   | meaning
    // IDLE    | waiting for arm
    // WAIT_VS | armed, waiting for vsync to fall (start of frame)
    // CAPTURE | assembling pixels from byte pairs and writing them
    // DONE    | one-cycle frame completion, then re-arm (cont) or idle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counters carry one extra count so that "one past the end" is representable
    // and the drop/error checks are plain comparisons.
    localparam int CW = $clog2(IMG_W + 1);
    localparam int LW = $clog2(IMG_H + 1);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] COL_LIM   = CW'(IMG_W);
    localparam logic [LW-1:0] LINE_LIM  = LW'(IMG_H);
    localparam logic [PW-1:0] PIX_TOTAL = PW'(IMG_W * IMG_H);

    state_t         state_q, state_d;
    logic           vsync_q, href_q;
    logic           phase_q, phase_d;
    logic [7:0]     b1_q, b1_d;
    logic [CW-1:0]  col_q, col_d;
    logic [LW-1:0]  line_q, line_d;
    logic [PW-1:0]  pix_q, pix_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic           wr_q, wr_d;
    logic           err_q, err_d;

    logic vs_fall, vs_rise, href_fall;
    assign vs_fall   = vsync_q & ~vsync;
    assign vs_rise   = ~vsync_q & vsync;
    assign href_fall = href_q & ~href;

    always_ff @(posedge clk_w or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            b1_q    <= '0;
            col_q   <= '0;
            line_q  <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            href_q  <= href;
            phase_q <= phase_d;
            b1_q    <= b1_d;
            col_q   <= col_d;
            line_q  <= line_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        b1_d    = b1_q;
        col_d   = col_q;
        line_d  = line_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT_VS;
                    err_d   = 1'b0;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d = CAPTURE;
                    phase_d = 1'b0;
                    col_d   = '0;
                    line_d  = '0;
                    pix_d   = '0;
                end
            end
            CAPTURE: begin
                // End of frame wins over any byte presented in the same cycle.
                if (vs_rise) begin
                    state_d = DONE;
                    if (pix_q != PIX_TOTAL) err_d = 1'b1;
                end else if (href) begin
                    if (!phase_q) begin
                        b1_d    = px_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q < COL_LIM && line_q < LINE_LIM) begin
                            wr_d   = 1'b1;
                            addr_d = pix_q[AW-1:0];
                            // RGB565 -> RGB444: keep the top bits of each channel
                            data_d = DW'({b1_q[7:4], b1_q[2:0], px_data[7], px_data[4:1]});
                            pix_d  = pix_q + PW'(1);
                            col_d  = col_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (href_fall) begin
                    if (phase_q) err_d = 1'b1;
                    phase_d = 1'b0;
                    col_d   = '0;
                    if (line_q < LINE_LIM) line_d = line_q + LW'(1);
                end
            end
            DONE: begin
                state_d = cont ? WAIT_VS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr_in   = addr_q;
    assign data_in   = data_q;
    assign regwrite  = wr_q;
    assign frame_err = err_q;
    assign done      = (state_q == DONE);
    // In continuous mode the single DONE cycle is still part of an ongoing
    // capture session, so busy does not drop between frames.
    assign busy      = (state_q == WAIT_VS) || (state_q == CAPTURE) ||
                       ((state_q == DONE) && cont);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
`timescale 1ns/1ps
module tb_cam_capture_ctrl;

    localparam int SW  = 20;
    localparam int SH  = 8;
    localparam int SAW = 8;

    logic       clk_w = 1'b0;
    logic       reset, vsync, href, arm, cont, sel;
    logic [7:0] px_data;
    logic       arm_s, arm_f;

    always #5 clk_w = ~clk_w;

    assign arm_s = arm & ~sel;
    assign arm_f = arm & sel;

    logic [SAW-1:0] addr_s;
    logic [11:0]    data_s;
    logic           rw_s, busy_s, done_s, err_s;
    logic [14:0]    addr_f;
    logic [11:0]    data_f;
    logic           rw_f, busy_f, done_f, err_f;

    cam_capture_ctrl #(.AW(SAW), .DW(12), .IMG_W(SW), .IMG_H(SH)) dut (
        .clk_w(clk_w), .reset(reset), .vsync(vsync), .href(href),
        .px_data(px_data), .arm(arm_s), .cont(cont),
        .addr_in(addr_s), .data_in(data_s), .regwrite(rw_s),
        .busy(busy_s), .done(done_s), .frame_err(err_s));

    cam_capture_ctrl dut_full (
        .clk_w(clk_w), .reset(reset), .vsync(vsync), .href(href),
        .px_data(px_data), .arm(arm_f), .cont(cont),
        .addr_in(addr_f), .data_in(data_f), .regwrite(rw_f),
        .busy(busy_f), .done(done_f), .frame_err(err_f));

    logic [14:0] addr_o;
    logic [11:0] data_o;
    logic        rw_o, busy_o, done_o, err_o, other_rw;
    assign addr_o   = sel ? addr_f : 15'(addr_s);
    assign data_o   = sel ? data_f : data_s;
    assign rw_o     = sel ? rw_f   : rw_s;
    assign busy_o   = sel ? busy_f : busy_s;
    assign done_o   = sel ? done_f : done_s;
    assign err_o    = sel ? err_f  : err_s;
    assign other_rw = sel ? rw_s   : rw_f;

    // ---------------- reference model state ----------------
    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t expq[$];
    int  cyc = 0;
    int  n_vec = 0, n_bad = 0, n_wr = 0, n_done = 0;
    int  exp_addr, exp_px, line_no, cur_w, cur_h, wr_base;
    bit  err_exp;

    always @(posedge clk_w) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // RGB565 channels reduced to 4 bits each by dropping low-order bits.
    function automatic int conv565(input int b1, input int b2);
        int r5, g6, b5;
        r5 = (b1 >> 3) & 31;
        g6 = ((b1 & 7) << 3) | ((b2 >> 5) & 7);
        b5 = b2 & 31;
        return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
    endfunction

    always @(negedge clk_w) begin
        wr_t e;
        chk("idle_dut_rw", other_rw, 0);
        if (done_o) n_done++;
        if (rw_o) begin
            n_wr++;
            chk("wr_was_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("wr_addr", addr_o, e.addr);
                chk("wr_data", data_o, e.data);
                chk("wr_latency", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic gen_line(input int n, input int mode, output int b[$]);
        b = {};
        for (int i = 0; i < n; i++) begin
            if (mode == 0) b.push_back((i % 2 == 0) ? 'hF8 : 'h1F);
            else           b.push_back(int'($urandom_range(0, 255)));
        end
    endtask

    task automatic drive_line(input int b[$]);
        int n;
        n = b.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk_w);
            href    = 1'b1;
            px_data = 8'(b[i]);
            if (i % 2 == 1) begin
                if (line_no < cur_h && i / 2 < cur_w) begin
                    expq.push_back('{exp_addr, conv565(b[i-1], b[i]), cyc + 1});
                    exp_addr++;
                    exp_px++;
                end else begin
                    err_exp = 1'b1;
                end
            end
        end
        if (n % 2 == 1) err_exp = 1'b1;
        @(negedge clk_w);
        href = 1'b0;
        @(negedge clk_w);
        line_no++;
    endtask

    task automatic do_arm();
        @(negedge clk_w);
        arm = 1'b1;
        @(negedge clk_w);
        arm = 1'b0;
        err_exp = 1'b0;
        chk("err_clr_on_arm", err_o, 0);
        chk("busy_after_arm", busy_o, 1);
    endtask

    task automatic begin_frame();
        vsync = 1'b1;
        repeat (3) begin
            @(negedge clk_w);
            chk("busy_wait_vs", busy_o, 1);
        end
        vsync    = 1'b0;
        exp_addr = 0;
        exp_px   = 0;
        line_no  = 0;
        wr_base  = n_wr;
        repeat (2) @(negedge clk_w);
    endtask

    task automatic end_frame();
        bit seen;
        if (!vsync) begin
            @(negedge clk_w);
            vsync = 1'b1;
        end
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk_w);
            href = 1'b0;
            if (done_o) seen = 1'b1;
        end
        if (exp_px != cur_w * cur_h) err_exp = 1'b1;
        chk("done_pulse", seen, 1);
        chk("frame_err", err_o, err_exp);
        chk("busy_in_done", busy_o, cont);
        chk("pix_count", n_wr - wr_base, exp_px);
        chk("expq_empty", expq.size(), 0);
        @(negedge clk_w);
        chk("done_one_cycle", done_o, 0);
        chk("busy_after_done", busy_o, cont);
    endtask

    task automatic full_lines(input int nlines, input int mode);
        int b[$];
        for (int l = 0; l < nlines; l++) begin
            gen_line(2 * cur_w, mode, b);
            drive_line(b);
        end
    endtask

    task automatic use_small();
        sel = 1'b0; cur_w = SW; cur_h = SH;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b[$];
        int dbase, n, len, nl;
        reset = 1'b1; vsync = 1'b1; href = 1'b0; arm = 1'b0; cont = 1'b0;
        px_data = 8'h00; sel = 1'b0;
        cur_w = SW; cur_h = SH; err_exp = 1'b0;
        repeat (2) @(negedge clk_w);
        chk("rst_rw",   rw_s,   0);  chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);  chk("rst_err",  err_s,  0);
        chk("rst_addr", addr_s, 0);  chk("rst_data", data_s, 0);
        chk("rst_rw_full", rw_f, 0); chk("rst_busy_full", busy_f, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_w);

        // full default-size frame of 0xF8,0x1F pairs
        sel = 1'b1; cur_w = 160; cur_h = 120;
        do_arm();
        begin_frame();
        full_lines(120, 0);
        end_frame();
        chk("full_last_addr", addr_o, 19199);
        chk("full_last_data", data_o, 'hF0F);

        use_small();

        // conversion and latency
        do_arm();
        begin_frame();
        b = '{'h07, 'hE0, 'h00, 'h1F};
        drive_line(b);
        end_frame();

        // overlong line, plus an arm in CAPTURE that must be ignored
        do_arm();
        begin_frame();
        full_lines(1, 1);
        gen_line(2 * cur_w + 10, 1, b);
        drive_line(b);
        @(negedge clk_w); arm = 1'b1;
        @(negedge clk_w); arm = 1'b0;
        chk("arm_ignored_busy", busy_o, 1);
        full_lines(cur_h - 2, 1);
        end_frame();

        // short frame ending with a byte that coincides with the vsync rise
        do_arm();
        begin_frame();
        full_lines(3, 1);
        @(negedge clk_w); href = 1'b1; px_data = 8'hAA;
        @(negedge clk_w); px_data = 8'h55; vsync = 1'b1;
        end_frame();

        // continuous mode, two frames
        dbase = n_done;
        do_arm();
        cont = 1'b1;
        begin_frame();
        full_lines(cur_h, 1);
        end_frame();
        begin_frame();
        full_lines(cur_h, 1);
        cont = 1'b0;
        end_frame();
        chk("cont_done_count", n_done - dbase, 2);

        // randomized frames
        for (int f = 0; f < 4; f++) begin
            do_arm();
            begin_frame();
            nl = int'($urandom_range(cur_h - 1, cur_h + 1));
            for (int l = 0; l < nl; l++) begin
                case ($urandom_range(0, 5))
                    0:       len = 2 * cur_w - 2;
                    1:       len = 2 * cur_w + 3;
                    2:       len = 1;
                    3:       len = 2 * cur_w + 6;
                    default: len = 2 * cur_w;
                endcase
                gen_line(len, 1, b);
                drive_line(b);
            end
            end_frame();
        end

        // reset in the middle of a frame
        do_arm();
        begin_frame();
        full_lines(3, 1);
        gen_line(2 * cur_w, 1, b);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_w);
            href = 1'b1; px_data = 8'(b[i]);
            if (i % 2 == 1) begin
                expq.push_back('{exp_addr, conv565(b[i-1], b[i]), cyc + 1});
                exp_addr++;
            end
        end
        @(negedge clk_w);
        chk("rw_before_reset", rw_o, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_rw",   rw_o,   0); chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0); chk("mid_rst_err",  err_o,  0);
        chk("mid_rst_addr", addr_o, 0); chk("mid_rst_data", data_o, 0);
        expq.delete();
        href = 1'b0;
        @(negedge clk_w);
        reset = 1'b0;
        wr_base = n_wr;
        vsync = 1'b1;
        repeat (3) @(negedge clk_w);
        vsync = 1'b0;
        repeat (2) @(negedge clk_w);
        n = 2 * cur_w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_w);
            href = 1'b1; px_data = 8'($urandom_range(0, 255));
        end
        @(negedge clk_w); href = 1'b0;
        repeat (3) @(negedge clk_w);
        chk("no_wr_after_reset", n_wr - wr_base, 0);
        chk("idle_after_reset", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 Parameter AW, default 15, frame-buffer address width.
REQ-002 Parameter DW, default 12, pixel width (RGB444).
REQ-003 Parameter IMG_W, default 160, pixels per line.
REQ-004 Parameter IMG_H, default 120, lines per frame; IMG_W*IMG_H SHALL be at most 2**AW.
REQ-005 clk_w  in  1  single clock; pixel-clock domain, drives the buffer write port.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 vsync  in  1  camera frame sync; high between frames.
REQ-008 href  in  1  camera line valid; high while bytes of a line are present.
REQ-009 px_data  in  8  camera byte, RGB565, high byte first; sampled on each clk_w rising edge while href=1.
REQ-010 arm  in  1  one-cycle capture request.
REQ-011 cont  in  1  continuous mode; 1 re-arms automatically after each frame.
REQ-012 addr_in  out  AW  buffer write address.
REQ-013 data_in  out  DW  buffer write data.
REQ-014 regwrite  out  1  buffer write enable, one-cycle pulse per pixel.
REQ-015 busy  out  1  high in WAIT_VS and CAPTURE.
REQ-016 done  out  1  one-cycle pulse at frame completion.
REQ-017 frame_err  out  1  sticky error flag; cleared by arm or reset.

Function
REQ-018 FSM states: IDLE, WAIT_VS, CAPTURE, DONE.
- IDLE->WAIT_VS on arm=1.
- WAIT_VS->CAPTURE on vsync falling edge (registered vsync 1, current 0).
- CAPTURE->DONE on vsync rising edge.
- DONE->WAIT_VS after one cycle if cont=1, else DONE->IDLE.
REQ-019 arm in any state other than IDLE SHALL be ignored.
REQ-020 In CAPTURE, byte phase SHALL toggle on each cycle with href=1; phase 0 latches the high byte (b1), phase 1 completes the pixel with the low byte (b2).
REQ-021 Pixel conversion: data_in = {b1[7:4], b1[2:0], b2[7], b2[4:1]}.
REQ-022 regwrite SHALL assert exactly one cycle after the edge that samples b2; addr_in and data_in SHALL be valid in that same cycle.
REQ-023 The first pixel of a frame SHALL use addr_in=0; addr_in SHALL increment by 1 after each regwrite; the last legal address is IMG_W*IMG_H-1 (19199 by default).
REQ-024 A column counter SHALL count pixels per line; pixels beyond IMG_W in a line SHALL be dropped (no regwrite) and SHALL set frame_err.
REQ-025 On an href falling edge: phase resets to 0, the column counter clears, and the line counter increments.
REQ-026 A lone odd byte at an href fall SHALL be discarded and SHALL set frame_err.
REQ-027 Lines with line counter >= IMG_H SHALL be dropped and SHALL set frame_err.
REQ-028 On a vsync rise in CAPTURE, frame_err SHALL set if the pixel count is not IMG_W*IMG_H.
- The done pulse SHALL occur in the DONE cycle regardless of frame_err.
REQ-029 Simultaneous href=1 and a vsync rise: the vsync rise takes priority, and the byte SHALL be discarded.
REQ-030 href/px_data outside CAPTURE SHALL produce no regwrite.
REQ-031 Pixel, column and line counters SHALL clear on entry to CAPTURE.

Reset
REQ-032 Asserting reset at any time, including mid-frame, SHALL immediately force:
- state=IDLE; addr_in=0, data_in=0;
- regwrite=0, busy=0, done=0, frame_err=0;
- all counters and phase = 0.
No write SHALL occur until a new arm followed by a vsync fall.

Verification
REQ-033 Full frame: arm, vsync 1->0, 120 lines of 320 bytes each, every pair 0xF8,0x1F -> 19200 regwrite pulses with data_in=0xF0F and addr_in 0..19199; done pulse on vsync rise; frame_err=0.
REQ-034 Conversion and latency: byte pair 0x07,0xE0 -> data_in=0x0F0 with regwrite one cycle after the 0xE0 sample; byte pair 0x00,0x1F -> data_in=0x00F.
REQ-035 Overlong line: line of 330 bytes -> exactly 160 writes for that line; frame_err=1; next line starts at addr_in=160.
REQ-036 Short frame: vsync rise after 10 lines -> done pulse; frame_err=1; 1600 writes; with cont=0, state returns to IDLE and busy=0.
REQ-037 Continuous mode: cont=1 with two full frames -> second frame restarts at addr_in=0; two done pulses; busy stays 1 between frames.
REQ-038 Reset mid-frame: reset asserted at pixel 5000 -> regwrite=0 and busy=0 immediately; subsequent href activity without arm -> no writes.
